hazard_control_unit: RTL
========================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter MD_TIMEOUT, default 32: maximum MD_WAIT cycles before timeout; legal range 2..255.
REQ-002 Parameter CNT_W, default 16: width of stall_cycles.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 ID_rs, ID_rt  input  3 each  source register addresses of the instruction in ID.
REQ-006 ID_uses_rt  input  1  ID instruction reads ID_rt.
REQ-007 ID_jump  input  1  jump decoded in ID.
REQ-008 EX_rd  input  3  destination register of the instruction in EX.
REQ-009 EX_memread  input  1  EX instruction is a load.
REQ-010 EX_branch_taken  input  1  branch resolved taken in EX.
REQ-011 EX_md_start  input  1  multi-cycle mul/div begins in EX this cycle.
REQ-012 md_done  input  1  mul/div unit result valid.
REQ-013 MEM_busy  input  1  data memory not ready.
REQ-014 clr_stats  input  1  clears stall_cycles.
REQ-015 pc_write, IF_ID_write, ID_EX_write, EX_MEM_write  output  1 each  register enables.
REQ-016 IF_ID_flush  output  1  zero IF/ID; has priority over IF_ID_write inside IF/ID.
REQ-017 ID_EX_bubble, EX_MEM_bubble  output  1 each  load NOP into ID/EX or EX/MEM.
REQ-018 md_timeout  output  1  sticky error flag.
REQ-019 stall_cycles  output  CNT_W  count of cycles with pc_write=0.

Function
REQ-020 FSM has two states: RUN and MD_WAIT; a registered MD counter has $clog2(MD_TIMEOUT)+1 bits.
REQ-021 All control outputs are combinational from state and inputs; the default is all writes=1 and flush/bubble=0.
REQ-022 Register R0 receives no special treatment; address compares are full 3-bit equality.
REQ-023 MEM_busy=1, in either state, takes highest priority: all four writes=0, flush/bubble=0, FSM state and MD counter frozen.
REQ-024 In RUN, with MEM_busy=0, the remaining conditions are evaluated in this priority order:
  a) EX_branch_taken: IF_ID_flush=1, ID_EX_bubble=1, writes=1.
  b) EX_md_start: pc_write=IF_ID_write=ID_EX_write=0, EX_MEM_bubble=1; next state MD_WAIT; MD counter cleared to 0.
  c) load-use, i.e. EX_memread and (EX_rd==ID_rs or (ID_uses_rt and EX_rd==ID_rt)): pc_write=IF_ID_write=0, ID_EX_bubble=1.
  d) ID_jump: IF_ID_flush=1.
REQ-025 MD_WAIT outputs (MEM_busy=0): pc_write=IF_ID_write=ID_EX_write=0, EX_MEM_bubble=1, EX_MEM_write=1.
REQ-026 In MD_WAIT, md_done=1 keeps the REQ-025 outputs for that cycle; next state is RUN.
REQ-027 In MD_WAIT, with md_done=0, the MD counter increments each cycle.
REQ-028 When the MD counter equals MD_TIMEOUT-1 and md_done=0: md_timeout is set, and next state is RUN.
REQ-029 md_done in RUN is ignored.
REQ-030 EX_branch_taken, EX_md_start and the load-use condition are ignored in MD_WAIT.
REQ-031 md_timeout, once set, holds until reset.
REQ-032 stall_cycles increments when pc_write=0.
REQ-033 stall_cycles saturates at 2^CNT_W-1.
REQ-034 clr_stats=1 loads stall_cycles with 0 and takes precedence over increment.
REQ-035 Simultaneous MEM_busy and EX_md_start in RUN: REQ-023 applies; the start is not taken; EX holds the instruction, so the start is re-presented next cycle.

Reset
REQ-036 While rst_n=0 at a clock edge, the block loads: state=RUN, MD counter=0, md_timeout=0, stall_cycles=0.
REQ-037 While rst_n=0, the block drives all writes=1 and flush/bubble=0, regardless of other inputs.
REQ-038 Reset asserted in MD_WAIT aborts the wait; the first cycle after rst_n=1 evaluates as RUN.

Verification
REQ-039 Load-use: EX_memread=1, EX_rd=3, ID_rs=3 -> pc_write=0, IF_ID_write=0, ID_EX_bubble=1 for exactly that cycle; stall_cycles 0->1.
REQ-040 Branch over load-use: EX_branch_taken=1 with the same load-use inputs -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1; stall_cycles unchanged.
REQ-041 MD op, cycles 0-4: EX_md_start at cycle 0, md_done at cycle 4 -> pc_write=0 for cycles 0..4.
REQ-042 MD op, cycle 5 onward: with the REQ-041 stimulus, state is RUN at cycle 5 and stall_cycles=5.
REQ-043 Timeout: MD_TIMEOUT=4, md_done never asserted -> md_timeout=1 after the 4th MD_WAIT cycle; RUN next cycle; md_timeout stays 1.
REQ-044 MEM_busy in MD_WAIT: assert for 3 cycles mid-wait -> all writes=0 and MD counter frozen for those cycles; wait length extends by 3.
REQ-045 Saturation: CNT_W=4, 20 stall cycles -> stall_cycles=15; then clr_stats together with a stall -> 0.

Source files
------------

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// Pipeline hazard controller for a five-stage in-order core. It decides each
// cycle which pipeline registers advance, which are flushed and where bubbles
// are inserted. It also tracks a multi-cycle mul/div wait with a timeout, and
// counts the cycles in which the PC was held.
//
// Parameters
//   MD_TIMEOUT   maximum number of MD_WAIT cycles before giving up (2..255)
//   CNT_W        width of the stall_cycles statistic counter
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   ID_rs, ID_rt, ID_uses_rt       source operands of the instruction in ID
//   ID_jump                        jump decoded in ID
//   EX_rd, EX_memread              destination / load flag of the EX instruction
//   EX_branch_taken                branch resolved taken in EX
//   EX_md_start                    mul/div starts in EX this cycle
//   md_done                        mul/div result valid
//   MEM_busy                       data memory not ready (freezes everything)
//   clr_stats                      clears stall_cycles
//   pc_write .. EX_MEM_write       pipeline register enables
//   IF_ID_flush                    zero IF/ID (wins over IF_ID_write)
//   ID_EX_bubble, EX_MEM_bubble    load a NOP into ID/EX or EX/MEM
//   md_timeout                     sticky flag: mul/div never finished
//   stall_cycles                   saturating count of cycles with pc_write=0
module hazard_control_unit #(
    parameter int MD_TIMEOUT = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ID_rs,
    input  logic [2:0]       ID_rt,
    input  logic             ID_uses_rt,
    input  logic             ID_jump,
    input  logic [2:0]       EX_rd,
    input  logic             EX_memread,
    input  logic             EX_branch_taken,
    input  logic             EX_md_start,
    input  logic             md_done,
    input  logic             MEM_busy,
    input  logic             clr_stats,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             ID_EX_write,
    output logic             EX_MEM_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_bubble,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int                 MD_CW     = $clog2(MD_TIMEOUT) + 1;
    localparam logic [MD_CW-1:0]   MD_LAST   = MD_CW'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STALL_MAX = '1;

    typedef enum logic {
        RUN,
        MD_WAIT
    } state_t;

    state_t           state;
    logic [MD_CW-1:0] md_cnt;
    logic             load_use;

    // A load in EX feeding an operand of the ID instruction. R0 is compared
    // like any other register.
    assign load_use = EX_memread &&
                      ((EX_rd == ID_rs) || (ID_uses_rt && (EX_rd == ID_rt)));

    // Control outputs are purely combinational so the pipeline reacts in the
    // same cycle the hazard is seen. While in reset the pipeline is allowed to
    // run freely so that it flushes itself out with the reset values.
    always_comb begin
        pc_write      = 1'b1;
        IF_ID_write   = 1'b1;
        ID_EX_write   = 1'b1;
        EX_MEM_write  = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_bubble  = 1'b0;
        EX_MEM_bubble = 1'b0;
        if (rst_n) begin
            if (MEM_busy) begin
                // Memory stall freezes the whole pipe, nothing is injected.
                pc_write     = 1'b0;
                IF_ID_write  = 1'b0;
                ID_EX_write  = 1'b0;
                EX_MEM_write = 1'b0;
            end else if (state == MD_WAIT || (!EX_branch_taken && EX_md_start)) begin
                // Front end holds while the mul/div runs; EX/MEM keeps
                // advancing with NOPs so older instructions drain.
                pc_write      = 1'b0;
                IF_ID_write   = 1'b0;
                ID_EX_write   = 1'b0;
                EX_MEM_bubble = 1'b1;
            end else if (EX_branch_taken) begin
                // Squash the two younger instructions fetched on the wrong path.
                IF_ID_flush  = 1'b1;
                ID_EX_bubble = 1'b1;
            end else if (load_use) begin
                pc_write     = 1'b0;
                IF_ID_write  = 1'b0;
                ID_EX_bubble = 1'b1;
            end else if (ID_jump) begin
                IF_ID_flush = 1'b1;
            end
        end
    end

    // Mul/div wait FSM. The counter counts completed wait cycles; reaching
    // MD_LAST without md_done means the unit is hung, so we flag it and
    // resume rather than stalling forever. MEM_busy freezes state and count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            md_cnt     <= '0;
            md_timeout <= 1'b0;
        end else if (!MEM_busy) begin
            case (state)
                RUN: begin
                    if (!EX_branch_taken && EX_md_start) begin
                        state  <= MD_WAIT;
                        md_cnt <= '0;
                    end
                end
                MD_WAIT: begin
                    if (md_done) begin
                        state <= RUN;
                    end else if (md_cnt == MD_LAST) begin
                        md_timeout <= 1'b1;
                        state      <= RUN;
                    end else begin
                        md_cnt <= md_cnt + MD_CW'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Saturating stall statistic; a clear request wins over counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (clr_stats) begin
            stall_cycles <= '0;
        end else if (!pc_write && (stall_cycles != STALL_MAX)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
